// File: rtl/mac3_sequencer_if.sv
// mac3_sequencer_if: operand, MAC, result and status bundle for mac3_sequencer
interface mac3_sequencer_if #(
    parameter int A_WIDTH           = 16,
    parameter int B_WIDTH           = 16,
    parameter int ACCUMULATOR_WIDTH = 32,
    parameter int OUTPUT_WIDTH      = 16,
    parameter int CNT_WIDTH         = 16
);
    logic                         start;
    logic [CNT_WIDTH-1:0]         cfg_groups;
    logic [CNT_WIDTH-1:0]         cfg_num_outputs;
    logic [31:0]                  cfg_ch_out_base;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [A_WIDTH-1:0]    in_a0, in_a1, in_a2;
    logic signed [B_WIDTH-1:0]    in_b0, in_b1, in_b2;
    logic [ACCUMULATOR_WIDTH-1:0] in_partial_sum;
    logic                         mac_input_valid;
    logic                         mac_accumulate_internal;
    logic                         mac_out_written_to_mem;
    logic [ACCUMULATOR_WIDTH-1:0] mac_partial_sum_in;
    logic [31:0]                  mac_ch_out_in;
    logic signed [A_WIDTH-1:0]    mac_a0, mac_a1, mac_a2;
    logic signed [B_WIDTH-1:0]    mac_b0, mac_b1, mac_b2;
    logic [OUTPUT_WIDTH-1:0]      mac_out;
    logic [31:0]                  mac_ch_out;
    logic                         res_valid;
    logic                         res_ready;
    logic [OUTPUT_WIDTH-1:0]      res_data;
    logic [31:0]                  res_ch_out;
    logic                         res_last;
    logic                         busy;
    logic                         done;

    modport master (
        input  start, cfg_groups, cfg_num_outputs, cfg_ch_out_base,
               in_valid, in_a0, in_a1, in_a2, in_b0, in_b1, in_b2, in_partial_sum,
               mac_out, mac_ch_out, res_ready,
        output in_ready, mac_input_valid, mac_accumulate_internal, mac_out_written_to_mem,
               mac_partial_sum_in, mac_ch_out_in, mac_a0, mac_a1, mac_a2, mac_b0, mac_b1, mac_b2,
               res_valid, res_data, res_ch_out, res_last, busy, done
    );

    modport slave (
        output start, cfg_groups, cfg_num_outputs, cfg_ch_out_base,
               in_valid, in_a0, in_a1, in_a2, in_b0, in_b1, in_b2, in_partial_sum,
               mac_out, mac_ch_out, res_ready,
        input  in_ready, mac_input_valid, mac_accumulate_internal, mac_out_written_to_mem,
               mac_partial_sum_in, mac_ch_out_in, mac_a0, mac_a1, mac_a2, mac_b0, mac_b1, mac_b2,
               res_valid, res_data, res_ch_out, res_last, busy, done
    );
endinterface

// File: rtl/mac3_sequencer.sv
// mac3_sequencer: issues operand groups into the mac3 pipeline and tracks results with a tag shift register
module mac3_sequencer #(
    parameter int A_WIDTH           = 16,
    parameter int B_WIDTH           = 16,
    parameter int ACCUMULATOR_WIDTH = 32,
    parameter int OUTPUT_WIDTH      = 16,
    parameter int MAC_LATENCY       = 4,
    parameter int CNT_WIDTH         = 16
) (
    input logic              clk,
    input logic              arst_n_in,
    mac3_sequencer_if.master bus
);
    localparam int DW = $clog2(MAC_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] groups, num_outputs, grp_cnt, out_cnt;
    logic [31:0]          base;
    logic [DW-1:0]        drain_cnt;
    logic [MAC_LATENCY-1:0] tag, last_tag;
    logic                 taken, head, res_valid, slot_ok, beat, bubble, adv, hs, last_grp, last_out;

    assign head      = tag[MAC_LATENCY-1];
    assign res_valid = head & ~taken;
    assign slot_ok   = ~res_valid | bus.res_ready;
    assign hs        = res_valid & bus.res_ready;
    assign beat      = (state == RUN) & bus.in_valid & slot_ok;
    assign bubble    = (state == DRAIN) & (drain_cnt != '0) & slot_ok;
    assign adv       = beat | bubble;
    assign last_grp  = grp_cnt == groups - 1'b1;
    assign last_out  = out_cnt == num_outputs - 1'b1;

    // state register
    always_ff @(posedge clk) begin
        if (!arst_n_in) state <= IDLE;
        else            state <= state_nxt;
    end

    // next-state: leave DRAIN only once every bubble has issued and the final result is taken
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = (bus.cfg_num_outputs == '0) ? FINISH : RUN;
            RUN:     if (beat && last_grp && last_out) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == '0 && slot_ok) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs: MAC side inputs are zero except on an advance, bubbles keep the accumulator
    always_comb begin
        bus.in_ready                = (state == RUN) & slot_ok;
        bus.mac_input_valid         = adv;
        bus.mac_accumulate_internal = beat ? (grp_cnt != '0) : bubble;
        bus.mac_out_written_to_mem  = beat & last_grp;
        bus.mac_partial_sum_in      = (beat && grp_cnt == '0) ? bus.in_partial_sum : ACCUMULATOR_WIDTH'(0);
        bus.mac_ch_out_in           = beat ? base + 32'(out_cnt) : 32'd0;
        bus.mac_a0                  = beat ? bus.in_a0 : A_WIDTH'(0);
        bus.mac_a1                  = beat ? bus.in_a1 : A_WIDTH'(0);
        bus.mac_a2                  = beat ? bus.in_a2 : A_WIDTH'(0);
        bus.mac_b0                  = beat ? bus.in_b0 : B_WIDTH'(0);
        bus.mac_b1                  = beat ? bus.in_b1 : B_WIDTH'(0);
        bus.mac_b2                  = beat ? bus.in_b2 : B_WIDTH'(0);
        bus.res_valid               = res_valid;
        bus.res_data                = bus.mac_out[OUTPUT_WIDTH-1:0];
        bus.res_ch_out              = bus.mac_ch_out;
        bus.res_last                = res_valid & last_tag[MAC_LATENCY-1];
        bus.busy                    = state != IDLE;
        bus.done                    = state == FINISH;
    end

    // job config, counters, and result tags that shift in lock-step with the MAC pipeline
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            groups      <= '0;
            num_outputs <= '0;
            base        <= '0;
            grp_cnt     <= '0;
            out_cnt     <= '0;
            drain_cnt   <= '0;
            tag         <= '0;
            last_tag    <= '0;
            taken       <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                groups      <= (bus.cfg_groups == '0) ? CNT_WIDTH'(1) : bus.cfg_groups;
                num_outputs <= bus.cfg_num_outputs;
                base        <= bus.cfg_ch_out_base;
                grp_cnt     <= '0;
                out_cnt     <= '0;
            end
            if (beat) begin
                grp_cnt <= last_grp ? '0 : grp_cnt + 1'b1;
                out_cnt <= last_grp ? out_cnt + 1'b1 : out_cnt;
                if (last_grp && last_out) drain_cnt <= DW'(MAC_LATENCY - 1);
            end
            if (bubble) drain_cnt <= drain_cnt - 1'b1;
            if (adv) begin
                tag      <= (tag << 1) | MAC_LATENCY'(beat & last_grp);
                last_tag <= (last_tag << 1) | MAC_LATENCY'(beat & last_grp & last_out);
            end
            taken <= adv ? 1'b0 : (taken | hs);
            if (state == FINISH) begin
                tag      <= '0;
                last_tag <= '0;
                taken    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac3_sequencer.sv
// tb_mac3_sequencer: directed jobs against a behavioural mac3 model with a result scoreboard
module tb_mac3_sequencer;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    mac3_sequencer_if bus ();
    mac3_sequencer dut (.clk(clk), .arst_n_in(arst_n), .bus(bus));

    typedef struct {
        logic signed [15:0] a0, a1, a2, b0, b1, b2;
        logic [31:0]        ps;
    } beat_t;
    typedef struct {
        logic [15:0] data;
        logic [31:0] ch;
        logic        last;
    } res_t;

    beat_t beat_q[$];
    res_t  exp_q[$];
    int    pop_cyc[$];
    int    vectors = 0, errors = 0;
    int    cyc = 0, adv_cnt = 0, done_cnt = 0, done_cyc = 0, last_pop_cyc = 0;
    bit    feed_fire;
    res_t  mon_e;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // behavioural mac3: accumulate at issue, result emerges after 4 advances
    int          acc = 0;
    logic [31:0] pv[4] = '{default: 0};
    logic [31:0] pc[4] = '{default: 0};
    always @(posedge clk) begin
        if (bus.mac_input_valid) begin
            acc = (bus.mac_accumulate_internal ? acc : int'(bus.mac_partial_sum_in))
                + int'(bus.mac_a0) * int'(bus.mac_b0)
                + int'(bus.mac_a1) * int'(bus.mac_b1)
                + int'(bus.mac_a2) * int'(bus.mac_b2);
            pv[0] <= acc; pv[1] <= pv[0]; pv[2] <= pv[1]; pv[3] <= pv[2];
            pc[0] <= bus.mac_ch_out_in; pc[1] <= pc[0]; pc[2] <= pc[1]; pc[3] <= pc[2];
        end
    end
    assign bus.mac_out    = pv[3][15:0];
    assign bus.mac_ch_out = pc[3];

    // cycle, advance and done bookkeeping
    always @(posedge clk) begin
        if (bus.mac_input_valid) adv_cnt++;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        cyc++;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected result: got data %0d ch %0d, none expected", bus.res_data, bus.res_ch_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_data", 64'(bus.res_data), 64'(mon_e.data));
                chk("res_ch_out", 64'(bus.res_ch_out), 64'(mon_e.ch));
                chk("res_last", 64'(bus.res_last), 64'(mon_e.last));
                pop_cyc.push_back(cyc);
                if (mon_e.last) last_pop_cyc = cyc;
            end
        end
    end

    task automatic present();
        beat_t f = '{default: 0};
        if (beat_q.size() > 0) f = beat_q[0];
        bus.in_valid       = beat_q.size() > 0;
        bus.in_a0          = f.a0;
        bus.in_a1          = f.a1;
        bus.in_a2          = f.a2;
        bus.in_b0          = f.b0;
        bus.in_b1          = f.b1;
        bus.in_b2          = f.b2;
        bus.in_partial_sum = f.ps;
    endtask

    // operand feeder
    initial begin
        present();
        forever begin
            @(negedge clk);
            feed_fire = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (feed_fire && beat_q.size() > 0) void'(beat_q.pop_front());
            present();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(int a0, int a1, int a2, int b0, int b1, int b2, int ps);
        beat_t b;
        b.a0 = 16'(a0); b.a1 = 16'(a1); b.a2 = 16'(a2);
        b.b0 = 16'(b0); b.b1 = 16'(b1); b.b2 = 16'(b2);
        b.ps = 32'(ps);
        beat_q.push_back(b);
    endtask

    task automatic push_exp(int data, int ch, bit last);
        res_t r;
        r.data = 16'(data);
        r.ch   = 32'(ch);
        r.last = last;
        exp_q.push_back(r);
    endtask

    task automatic start_job(int g, int n, int base);
        bus.cfg_groups      = 16'(g);
        bus.cfg_num_outputs = 16'(n);
        bus.cfg_ch_out_base = 32'(base);
        bus.start           = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.done && k < 400);
        chk({name, " done"}, 64'(bus.done), 64'd1);
        chk({name, " queue drained"}, 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    task automatic chk_idle_outputs(string name);
        chk({name, " busy"}, 64'(bus.busy), 0);
        chk({name, " done"}, 64'(bus.done), 0);
        chk({name, " res_valid"}, 64'(bus.res_valid), 0);
        chk({name, " in_ready"}, 64'(bus.in_ready), 0);
        chk({name, " mac_input_valid"}, 64'(bus.mac_input_valid), 0);
        chk({name, " mac_accumulate_internal"}, 64'(bus.mac_accumulate_internal), 0);
        chk({name, " mac_a0"}, 64'(bus.mac_a0), 0);
        chk({name, " mac_b2"}, 64'(bus.mac_b2), 0);
        chk({name, " mac_partial_sum_in"}, 64'(bus.mac_partial_sum_in), 0);
        chk({name, " mac_ch_out_in"}, 64'(bus.mac_ch_out_in), 0);
    endtask

    initial begin
        int a_before, d_before, k;
        bus.start = 1'b0;
        bus.cfg_groups = '0;
        bus.cfg_num_outputs = '0;
        bus.cfg_ch_out_base = '0;
        bus.res_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk_idle_outputs("reset");
        tick();
        arst_n = 1'b1;
        tick();

        // G=2, N=1, seed 10: 32+10 then +3 = 45
        push_beat(1, 2, 3, 4, 5, 6, 10);
        push_beat(1, 1, 1, 1, 1, 1, 0);
        push_exp(45, 100, 1'b1);
        a_before = adv_cnt;
        start_job(2, 1, 100);
        wait_done("t1");
        chk("t1 advances", 64'(adv_cnt - a_before), 64'd5);
        chk("t1 done after accept", 64'(done_cyc), 64'(last_pop_cyc + 1));

        // G=1, N=4, base 7: one result per cycle
        pop_cyc.delete();
        for (int i = 1; i <= 4; i++) begin
            push_beat(i, 0, 0, 1, 0, 0, 0);
            push_exp(i, 6 + i, i == 4);
        end
        a_before = adv_cnt;
        start_job(1, 4, 7);
        wait_done("t2");
        chk("t2 advances", 64'(adv_cnt - a_before), 64'd7);
        chk("t2 spacing", 64'(pop_cyc.size() == 4 ? pop_cyc[3] - pop_cyc[0] : -1), 64'd3);

        // same job, first result held for 5 cycles
        for (int i = 1; i <= 4; i++) begin
            push_beat(i, 0, 0, 1, 0, 0, 0);
            push_exp(i, 6 + i, i == 4);
        end
        bus.res_ready = 1'b0;
        start_job(1, 4, 7);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.res_valid && k < 50);
        for (int i = 0; i < 5; i++) begin
            chk("t3 res_valid held", 64'(bus.res_valid), 64'd1);
            chk("t3 in_ready", 64'(bus.in_ready), 64'd0);
            chk("t3 mac_input_valid", 64'(bus.mac_input_valid), 64'd0);
            chk("t3 res_data held", 64'(bus.res_data), 64'd1);
            if (i < 4) @(negedge clk);
        end
        tick();
        bus.res_ready = 1'b1;
        wait_done("t3");

        // N=0: done with no MAC activity
        a_before = adv_cnt;
        d_before = done_cnt;
        start_job(3, 0, 5);
        wait_done("t4");
        chk("t4 advances", 64'(adv_cnt - a_before), 64'd0);
        chk("t4 done pulses", 64'(done_cnt - d_before), 64'd1);

        // reset mid-run with results in flight
        for (int i = 1; i <= 8; i++) begin
            push_beat(i, 0, 0, 1, 0, 0, 0);
            push_exp(i, 6 + i, i == 8);
        end
        a_before = adv_cnt;
        start_job(1, 8, 7);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (adv_cnt - a_before < 1 && k < 50);
        tick();
        arst_n = 1'b0;
        beat_q.delete();
        exp_q.delete();
        tick();
        @(negedge clk);
        chk_idle_outputs("mid-run reset");
        tick();
        arst_n = 1'b1;
        tick();

        // negative operands, G=3, seed -5; partial sum on later groups must be ignored
        push_beat(-1, -2, -3, 100, 100, 100, -5);
        push_beat(-1, -2, -3, 100, 100, 100, 999);
        push_beat(-1, -2, -3, 100, 100, 100, 999);
        push_exp(-1805, 32, 1'b1);
        start_job(3, 1, 32);
        wait_done("t6");

        // G=0 behaves as G=1
        push_beat(2, 0, 0, 3, 0, 0, 1);
        push_beat(5, 0, 0, 5, 0, 0, 0);
        push_exp(7, 50, 1'b0);
        push_exp(25, 51, 1'b1);
        start_job(0, 2, 50);
        wait_done("t7");

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/mac3_sequencer.md
# mac3_sequencer

Issue-side controller for the 3-tap `mac3` MAC pipeline. It accepts a job of N output pixels of G three-tap groups each, and streams operand triplets into the MAC. It drives `accumulate_internal`, `partial_sum_in` and the channel tag, and tracks each result through the pipeline with its own tag shift register. Finished results are presented on a valid/ready port to the output-memory writer. The MAC pipeline advances only on cycles where the sequencer asserts `mac_input_valid`, so the sequencer also owns flushing and back-pressure.

## Interface
Parameters:
- `A_WIDTH`, 16, operand a width (signed)
- `B_WIDTH`, 16, operand b width (signed)
- `ACCUMULATOR_WIDTH`, 32, partial-sum width
- `OUTPUT_WIDTH`, 16, MAC result width
- `MAC_LATENCY`, 4, MAC advances from issue to result visible on `mac_out`
- `CNT_WIDTH`, 16, width of the group and output counters

Ports:
- `clk` in 1: clock. One clock; reset is synchronous and active-low.
- `arst_n_in` in 1: reset, synchronous, active-low.
- `start` in 1: begin a job; sampled only in IDLE.
- `cfg_groups` in CNT_WIDTH: groups per output (G); 0 is treated as 1.
- `cfg_num_outputs` in CNT_WIDTH: outputs per job (N).
- `cfg_ch_out_base` in 32: channel tag of output 0.
- `in_valid` in 1 / `in_ready` out 1: operand-stream handshake.
- `in_a0..in_a2` in A_WIDTH, `in_b0..in_b2` in B_WIDTH: one group.
- `in_partial_sum` in ACCUMULATOR_WIDTH: seed; used only on a group-0 beat.
- `mac_input_valid`, `mac_accumulate_internal`, `mac_out_written_to_mem` out 1: MAC controls.
- `mac_partial_sum_in` out ACCUMULATOR_WIDTH, `mac_ch_out_in` out 32: MAC side inputs.
- `mac_a0..mac_a2` out A_WIDTH, `mac_b0..mac_b2` out B_WIDTH: MAC operands.
- `mac_out` in OUTPUT_WIDTH, `mac_ch_out` in 32: MAC stage-4 result and tag.
- `res_valid` out 1 / `res_ready` in 1: result handshake.
- `res_data` out OUTPUT_WIDTH, `res_ch_out` out 32, `res_last` out 1: result fields.
- `busy` out 1, `done` out 1: status; `done` is a one-cycle pulse.

## Operation
- States: IDLE, RUN, DRAIN, FINISH.
- IDLE -> RUN on `start`: latch G, N and base; clear `grp_cnt` and `out_cnt`.
  - If N==0, go IDLE -> FINISH instead, with no MAC activity.
- Head signals:
  - `head = tag[MAC_LATENCY-1]`.
  - `res_valid = head & !taken`.
  - `slot_ok = !res_valid | res_ready`.
- Advance (`mac_input_valid`) fires when `slot_ok` holds and one of:
  - RUN with `in_valid` (an operand beat; `in_ready = (state==RUN) & slot_ok`);
  - DRAIN (a bubble beat).
- Operand beat:
  - Operands pass through to the MAC.
  - `mac_accumulate_internal = (grp_cnt != 0)`.
  - `mac_partial_sum_in = in_partial_sum` when grp_cnt==0, else 0.
  - `mac_ch_out_in = base + out_cnt` (32-bit wrap).
  - `mac_out_written_to_mem` and the shifted-in tag bit are both `grp_cnt == G-1`.
  - `grp_cnt` wraps to 0 at G-1 and `out_cnt` increments.
  - The last group of output N-1 moves RUN -> DRAIN and loads `drain_cnt = MAC_LATENCY-1`.
- Bubble beat:
  - Operands and partial sum 0, `accumulate_internal = 1`, tag bit 0.
  - `drain_cnt` decrements.
  - DRAIN -> FINISH after the last bubble has advanced and the head has been consumed.
- Every advance shifts `tag` and clears `taken`. A handshake (`res_valid & res_ready`) without an advance sets `taken`.
- Result fields:
  - `res_data = mac_out` and `res_ch_out = mac_ch_out`, combinational pass-through.
  - `res_last` is high on the result of output N-1.
- FINISH: `done` for one cycle, then IDLE.
- `busy` is high in every state except IDLE.
- `start` outside IDLE is ignored.

## Timing
- Reset values: all state, counters, `tag` and `taken` clear; state IDLE.
  - All control outputs, `busy`, `done` and `res_valid` are 0.
  - `mac_*` data outputs are 0.
- Reset mid-job aborts immediately. Results still in the MAC are discarded because `tag` is cleared.
- Latency:
  - A result becomes valid in the cycle after the MAC_LATENCY-th advance counting its own last-group beat.
  - With back-to-back outputs there is one result every G advances.
- Back-pressure: while a result is unaccepted, no advance occurs, so `in_ready` is 0. With `res_ready` high in that cycle, advance and handshake happen together.
- `in_valid` low in RUN means no advance; the MAC state is frozen.
- Simultaneous handshake and final bubble: both take effect. FINISH is entered only once the last result is consumed.

## Test plan
- G=2, N=1, seed 10:
  - group0 a=(1,2,3), b=(4,5,6); group1 all 1s.
  - Expect 2 beats, 3 bubbles, then `res_data`=45 with `res_last`=1 and `res_ch_out`=base.
  - Then `done` one cycle later after accept.
- G=1, N=4, base=7, each beat yields a product of k (k=1..4), continuous valid:
  - `res_data` 1,2,3,4 on consecutive cycles.
  - `res_ch_out` 7..10.
- Same as the previous case with `res_ready` low for 5 cycles at the first result:
  - `in_ready` low, `res_data` held at 1 with no advance.
  - On release, the sequence continues intact.
- N=0, `start`:
  - `done` pulses with no `mac_input_valid` ever asserted.
- Reset asserted mid-RUN with 2 results in flight:
  - Next cycle all outputs are 0 and state is IDLE.
  - A new job produces correct results with no stale results.
- Negative operands, G=3, N=1:
  - a=(-1,-2,-3), b=(100,100,100) for every group, seed -5.
  - Expect `res_data` = -1805.
